// File: rtl/px_pattern_check_pkg.sv
// Shared sensor definitions used by the pixel pattern checker:
// FSM encoding, default pixel width and the saturating counter helper.
package px_pattern_check_pkg;

  localparam int PX_DATA_WIDTH = 12;
  localparam int CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_CHECK     = 2'd2,
    ST_UPDATE    = 2'd3
  } Fsm_e;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] value);
    return (value == {CNT_WIDTH{1'b1}}) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/px_pattern_check.sv
// Training-pattern checker: measures the longest run of matching pixels per line
// and reports a registered lock verdict one cycle after each line ends.
module px_pattern_check
  import px_pattern_check_pkg::*;
#(
  parameter int    DATA_WIDTH = PX_DATA_WIDTH,
  parameter string DEBUG      = "FALSE"
) (
  input  logic                  px_clk,
  input  logic                  px_reset_n,
  input  logic                  en,
  input  logic                  cfg_change,
  input  logic                  line_start,
  input  logic                  px_valid,
  input  logic [DATA_WIDTH-1:0] px_data,
  input  logic [DATA_WIDTH-1:0] TRAIN_PATTERN,
  input  logic [15:0]           FRAME_WIDTH,
  input  logic [15:0]           CHECK_PATTERN_NUM,
  output logic                  pattern_locked,
  output logic                  line_checked,
  output logic [15:0]           max_run_out,
  output Fsm_e                  dbg_state_o,
  output logic [15:0]           dbg_pix_cnt_o,
  output logic [15:0]           dbg_cur_run_o,
  output logic [15:0]           dbg_max_run_o,
  output logic                  dbg_full_line_o
);

  localparam bit DebugEn = (DEBUG == "TRUE");

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic [1:0]            rstSync_q;
  logic                  rstSync_n;

  Fsm_e                  state_q;
  cnt_t                  pixCnt_q;
  cnt_t                  curRun_q;
  cnt_t                  maxRun_q;
  cnt_t                  frameWidth_q;
  cnt_t                  checkNum_q;
  logic [DATA_WIDTH-1:0] train_q;
  logic                  fullLine_q;
  logic                  locked_q;
  logic                  checked_q;
  cnt_t                  maxRunOut_q;

  logic                  startMatch;
  logic                  startDone;
  logic                  startLock;
  logic                  beginLine;
  logic                  lineDone;
  cnt_t                  startRun;
  cnt_t                  pixCnt_d;
  cnt_t                  curRun_d;
  cnt_t                  maxRun_d;

  // Reset asserts immediately but releases only on a clock edge, two flops deep.
  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSync_n = rstSync_q[1];

  // The start-of-line values use the live configuration, since it is being captured on that pixel.
  always_comb begin
    startMatch = (px_data == TRAIN_PATTERN);
    startRun   = startMatch ? cnt_t'(1) : '0;
    startDone  = (FRAME_WIDTH == cnt_t'(1));
    startLock  = (startRun >= CHECK_PATTERN_NUM);
    pixCnt_d   = satInc(pixCnt_q);
    curRun_d   = (px_data == train_q) ? satInc(curRun_q) : '0;
    maxRun_d   = (curRun_d > maxRun_q) ? curRun_d : maxRun_q;
    lineDone   = (pixCnt_d == frameWidth_q);
    beginLine  = px_valid && line_start && en && !cfg_change && (state_q != ST_IDLE);
  end

  always_ff @(posedge px_clk or negedge rstSync_n) begin
    if (!rstSync_n) begin
      state_q      <= ST_IDLE;
      pixCnt_q     <= '0;
      curRun_q     <= '0;
      maxRun_q     <= '0;
      frameWidth_q <= '0;
      checkNum_q   <= '0;
      train_q      <= '0;
      fullLine_q   <= 1'b0;
      locked_q     <= 1'b0;
      checked_q    <= 1'b0;
      maxRunOut_q  <= '0;
    end else begin
      checked_q <= 1'b0;
      if ((state_q != ST_IDLE) && !en) begin
        state_q     <= ST_IDLE;
        locked_q    <= 1'b0;
        maxRunOut_q <= '0;
        pixCnt_q    <= '0;
        curRun_q    <= '0;
        maxRun_q    <= '0;
        fullLine_q  <= 1'b0;
      end else if ((state_q != ST_IDLE) && cfg_change) begin
        state_q    <= ST_WAIT_LINE;
        locked_q   <= 1'b0;
        pixCnt_q   <= '0;
        curRun_q   <= '0;
        maxRun_q   <= '0;
        fullLine_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            locked_q    <= 1'b0;
            maxRunOut_q <= '0;
            pixCnt_q    <= '0;
            curRun_q    <= '0;
            maxRun_q    <= '0;
            if (en && (FRAME_WIDTH != '0)) begin
              state_q <= ST_WAIT_LINE;
            end
          end
          ST_WAIT_LINE: begin
          end
          ST_CHECK: begin
            if (px_valid && line_start) begin
              locked_q    <= 1'b0;
              checked_q   <= 1'b1;
              maxRunOut_q <= maxRun_q;
              fullLine_q  <= 1'b0;
            end else if (px_valid) begin
              pixCnt_q <= pixCnt_d;
              curRun_q <= curRun_d;
              maxRun_q <= maxRun_d;
              if (lineDone) begin
                locked_q    <= (maxRun_d >= checkNum_q);
                checked_q   <= 1'b1;
                maxRunOut_q <= maxRun_d;
                fullLine_q  <= 1'b1;
                state_q     <= ST_UPDATE;
              end
            end
          end
          ST_UPDATE: begin
            pixCnt_q <= '0;
            curRun_q <= '0;
            maxRun_q <= '0;
            state_q  <= ST_WAIT_LINE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase

        // A new line (also the one that cuts a short line) overrides whatever the state chose.
        if (beginLine) begin
          frameWidth_q <= FRAME_WIDTH;
          checkNum_q   <= CHECK_PATTERN_NUM;
          train_q      <= TRAIN_PATTERN;
          pixCnt_q     <= cnt_t'(1);
          curRun_q     <= startRun;
          maxRun_q     <= startRun;
          if (startDone) begin
            locked_q    <= startLock;
            checked_q   <= 1'b1;
            maxRunOut_q <= startRun;
            fullLine_q  <= 1'b1;
            state_q     <= ST_UPDATE;
          end else begin
            fullLine_q <= 1'b0;
            state_q    <= ST_CHECK;
          end
        end
      end
    end
  end

  assign pattern_locked  = locked_q;
  assign line_checked    = checked_q;
  assign max_run_out     = maxRunOut_q;

  assign dbg_state_o     = DebugEn ? state_q : ST_IDLE;
  assign dbg_pix_cnt_o   = DebugEn ? pixCnt_q : '0;
  assign dbg_cur_run_o   = DebugEn ? curRun_q : '0;
  assign dbg_max_run_o   = DebugEn ? maxRun_q : '0;
  assign dbg_full_line_o = DebugEn ? fullLine_q : 1'b0;

endmodule
